// File: rtl/data_memory_pkg.sv
// Shared constants and types for the RV32I data memory slice.
package data_memory_pkg;

   localparam int DMEM_DEPTH  = 64;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_IDX_W  = $clog2(DMEM_DEPTH);

   typedef logic [DMEM_DATA_W-1:0] dmem_word_t;
   typedef logic [DMEM_IDX_W-1:0]  dmem_idx_t;

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index decode, plus a flag for any address bit above the index field.
module dmem_addr_decode
   import data_memory_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int IDX_W  = DMEM_IDX_W
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              range_flag
);

   assign idx = addr[IDX_W+1:2];

   generate
      if (ADDR_W > IDX_W + 2) begin : g_upper
         assign range_flag = |addr[ADDR_W-1:IDX_W+2];
      end else begin : g_no_upper
         assign range_flag = 1'b0;
      end
   endgenerate

   // Byte-lane bits never select anything; accesses are whole aligned words.
   logic unused_lsb;
   assign unused_lsb = ^addr[1:0];

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous write, combinational read, asynchronous clear.
// Optional out-of-range detection enabled with `define DATA_MEMORY_RANGE_ERR_EN.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int DEPTH  = DMEM_DEPTH,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data
`ifdef DATA_MEMORY_RANGE_ERR_EN
   ,
   output logic              range_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              range_flag;
   logic              blocked;
   logic              wr_en;

   dmem_addr_decode #(
      .ADDR_W(ADDR_W),
      .IDX_W (IDX_W)
   ) u_decode (
      .addr      (addr),
      .idx       (idx),
      .range_flag(range_flag)
   );

`ifdef DATA_MEMORY_RANGE_ERR_EN
   assign range_err = range_flag & ~reset;
   assign blocked   = range_flag;
`else
   // Upper address bits alias onto the array, so the flag has no consumer.
   logic unused_range;
   assign unused_range = range_flag;
   assign blocked      = 1'b0;
`endif

   assign wr_en = write_enable & ~clk_enable_n & ~blocked;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[idx] <= write_data;
      end
   end

   // Forced to zero during reset so the output never depends on array state mid-clear.
   assign read_data = (reset || blocked) ? '0 : mem[idx];

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against a word-array reference model.
module tb_data_memory;

   localparam int DEPTH  = 64;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              clk_enable_n;
   logic              write_enable;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
`ifdef DATA_MEMORY_RANGE_ERR_EN
   logic              range_err;
`endif

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] model [DEPTH];

   data_memory #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_enable_n(clk_enable_n),
      .write_enable(write_enable),
      .addr        (addr),
      .write_data  (write_data),
      .read_data   (read_data)
`ifdef DATA_MEMORY_RANGE_ERR_EN
      ,
      .range_err   (range_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic int word_of(input logic [ADDR_W-1:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   function automatic bit out_of_range(input logic [ADDR_W-1:0] a);
`ifdef DATA_MEMORY_RANGE_ERR_EN
      return a >= 32'(DEPTH * 4);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
      if (reset || out_of_range(a)) return '0;
      return model[word_of(a)];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // Advance one rising edge, apply the store rule to the model, and return at the falling edge.
   task automatic step();
      @(posedge clk);
      if (!reset && write_enable && !clk_enable_n && !out_of_range(addr))
         model[word_of(addr)] = write_data;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [ADDR_W-1:0] probe [3];
      probe[0] = 0;
      probe[1] = 4;
      probe[2] = 32'(4 * (DEPTH - 1));
      reset = 1'b1; clk_enable_n = 1'b0; write_enable = 1'b0;
      addr = 4; write_data = '0;
      clear_model();
      step();
      step();
      checks++;
      if (read_data !== '0) begin
         errors++;
         $display("FAIL reset_hold: read_data=%h expected=%h", read_data, 32'h0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         addr = probe[i];
         #1;
         checks++;
         if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_value addr=%h: read_data=%h expected=%h", addr, read_data, 32'h0);
         end
      end
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 32; i++) begin
         addr = 32'(4 * i);
         write_enable = 1'b1; write_data = 32'hF0F0_F0F0;
         step();
         checks++;
         if (read_data !== 32'hF0F0_F0F0) begin
            errors++;
            $display("FAIL write_read addr=%h: read_data=%h expected=%h", addr, read_data, 32'hF0F0_F0F0);
         end
         write_enable = 1'b0; write_data = 32'h0F0F_0F0F;
         step();
         checks++;
         if (read_data !== 32'hF0F0_F0F0) begin
            errors++;
            $display("FAIL write_hold addr=%h: read_data=%h expected=%h", addr, read_data, 32'hF0F0_F0F0);
         end
      end
   endtask

   task automatic test_overwrite();
      for (int i = 0; i < 32; i++) begin
         addr = 32'(4 * i);
         write_enable = 1'b1; write_data = 32'h0F0F_0F0F;
         step();
         checks++;
         if (read_data !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL overwrite addr=%h: read_data=%h expected=%h", addr, read_data, 32'h0F0F_0F0F);
         end
      end
      write_enable = 1'b0;
   endtask

   task automatic test_enable_gating();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      clear_model();
      clk_enable_n = 1'b1; write_enable = 1'b1;
      addr = 8; write_data = 32'h1234_5678;
      step();
      checks++;
      if (read_data !== 32'h0) begin
         errors++;
         $display("FAIL enable_gating: read_data=%h expected=%h", read_data, 32'h0);
      end
      clk_enable_n = 1'b0; write_enable = 1'b0;
   endtask

   task automatic test_async_reset();
      addr = 12; write_enable = 1'b1; write_data = 32'hDEAD_BEEF;
      step();
      write_enable = 1'b0;
      checks++;
      if (read_data !== exp_read(addr) || read_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL async_pre_write: read_data=%h expected=%h", read_data, 32'hDEAD_BEEF);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_immediate: read_data=%h expected=%h", read_data, 32'h0);
      end
      write_enable = 1'b1; write_data = 32'hCAFE_F00D;
      step();
      checks++;
      if (read_data !== 32'h0) begin
         errors++;
         $display("FAIL write_during_reset: read_data=%h expected=%h", read_data, 32'h0);
      end
      write_enable = 1'b0;
      reset = 1'b0;
      clear_model();
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         errors++;
         $display("FAIL after_reset_word3: read_data=%h expected=%h", read_data, 32'h0);
      end
   endtask

   task automatic test_alias();
      addr = 32'(4 * DEPTH); write_enable = 1'b1; write_data = 32'hA5A5_A5A5;
      step();
      write_enable = 1'b0;
`ifdef DATA_MEMORY_RANGE_ERR_EN
      checks++;
      if (range_err !== 1'b1) begin
         errors++;
         $display("FAIL range_err_flag: range_err=%b expected=%b", range_err, 1'b1);
      end
      checks++;
      if (read_data !== 32'h0) begin
         errors++;
         $display("FAIL range_read_zero: read_data=%h expected=%h", read_data, 32'h0);
      end
      addr = 0;
      #1;
      checks++;
      if (read_data !== exp_read(0) || range_err !== 1'b0) begin
         errors++;
         $display("FAIL range_word0: read_data=%h range_err=%b expected=%h/0", read_data, range_err, exp_read(0));
      end
`else
      addr = 0;
      #1;
      checks++;
      if (read_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL alias_word0: read_data=%h expected=%h", read_data, 32'hA5A5_A5A5);
      end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
`ifdef DATA_MEMORY_RANGE_ERR_EN
         addr = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, DEPTH * 4 - 1));
`else
         addr = 32'($urandom);
`endif
         write_enable = 1'($urandom_range(0, 1));
         clk_enable_n = ($urandom_range(0, 3) == 0);
         write_data = 32'($urandom);
         #1;
         checks++;
         if (read_data !== exp_read(addr)) begin
            errors++;
            $display("FAIL random_pre n=%0d addr=%h: read_data=%h expected=%h", n, addr, read_data, exp_read(addr));
         end
         step();
         checks++;
         if (read_data !== exp_read(addr)) begin
            errors++;
            $display("FAIL random_post n=%0d addr=%h: read_data=%h expected=%h", n, addr, read_data, exp_read(addr));
         end
`ifdef DATA_MEMORY_RANGE_ERR_EN
         checks++;
         if (range_err !== out_of_range(addr)) begin
            errors++;
            $display("FAIL random_range n=%0d addr=%h: range_err=%b expected=%b", n, addr, range_err, out_of_range(addr));
         end
`endif
      end
      write_enable = 1'b0; clk_enable_n = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_overwrite();
      test_enable_gating();
      test_async_reset();
      test_alias();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
